// File: rtl/rnn_decoder_if.sv
// rnn_decoder_if: stream handshakes for the rnn decoder.
//   in_*  : accumulated samples from the encoder side (plus sync)
//   out_* : decoded samples towards downstream
// slave is the decoder's view, master is the source/sink side.
interface rnn_decoder_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             sync;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, sync, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, sync, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/rnn_decoder.sv
// rnn_decoder: recovers current[n] = x[n] - x[n-1] (mod 2^WIDTH) from an
// accumulated sample stream and queues results in a DEPTH-entry FIFO.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : rnn_decoder_if slave (input stream, sync, output stream)
//   level      : FIFO occupancy 0..DEPTH
//   count      : accepted samples since reset, wraps at 16 bits
module rnn_decoder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  rnn_decoder_if.slave            bus,
  output logic [$clog2(DEPTH):0]  level,
  output logic [15:0]             count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] pred_c;
  logic [WIDTH-1:0] dec_c;
  logic             accept_c;
  logic             pop_c;

  // Flags come straight from the level register: no input-to-output path.
  assign bus.in_ready  = (level != LW'(DEPTH));
  assign bus.out_valid = (level != '0);

  assign accept_c = bus.in_valid && bus.in_ready;
  assign pop_c    = bus.out_valid && bus.out_ready;

  // Sync on the accepting cycle decodes against the encoder's zero state.
  assign pred_c = bus.sync ? '0 : prev;
  assign dec_c  = bus.in_data - pred_c;

  // Head entry read from storage; only meaningful while out_valid.
  assign bus.out_data = mem[rd_ptr[AW-1:0]];

  // Sample storage, no reset needed.
  always_ff @(posedge clk) begin
    if (accept_c) begin
      mem[wr_ptr[AW-1:0]] <= dec_c;
    end
  end

  // Pointers, occupancy, predictor and sample counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      prev   <= '0;
      count  <= '0;
    end else begin
      if (accept_c) begin
        wr_ptr <= wr_ptr + PW'(1);
        prev   <= bus.in_data;
        count  <= count + 16'd1;
      end else if (bus.sync) begin
        prev <= '0;
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({accept_c, pop_c})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_rnn_decoder.sv
// tb_rnn_decoder: directed table plus hand-written multi-cycle sequences.
module tb_rnn_decoder;

  logic        clk;
  logic        rst_n;
  logic [2:0]  level;
  logic [15:0] count;

  rnn_decoder_if #(.WIDTH(8)) bus ();

  rnn_decoder #(.WIDTH(8), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .level (level),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic       vld;
    logic       syn;
    logic       ordy;
    logic       exp_ov;
    logic [7:0] exp_od;
    int         exp_lvl;
    int         exp_cnt;
  } vec_t;

  vec_t       tbl [10];
  int         nvec;
  int         nerr;
  int         max_lvl;
  logic       last_acc;
  logic [7:0] got [$];
  logic [7:0] exp_q [$];
  logic [7:0] acc_m;
  logic [7:0] cur;

  task automatic chk(input string nm, input int act, input int exp_v);
    nvec++;
    if (act != exp_v) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // One clock: record handshakes just before the edge, then settle after it.
  task automatic cyc();
    last_acc = bus.in_valid && bus.in_ready;
    if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
    @(posedge clk);
    #1;
    if (int'(level) > max_lvl) max_lvl = int'(level);
  endtask

  task automatic idle_inputs();
    bus.in_data   = 8'd0;
    bus.in_valid  = 1'b0;
    bus.sync      = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  // Asynchronous assertion, checked immediately, released away from the edge.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_count", int'(count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got.delete();
    exp_q.delete();
    max_lvl = 0;
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    rst_n = 1'b1;
    idle_inputs();

    //           din   v  s  r   ov  od      lvl cnt
    tbl[0] = '{8'd5,   1, 0, 1,  1, 8'd5,   1, 1};
    tbl[1] = '{8'd8,   1, 0, 1,  1, 8'd3,   1, 2};
    tbl[2] = '{8'd2,   1, 0, 1,  1, 8'd250, 1, 3};
    tbl[3] = '{8'd0,   0, 1, 1,  0, 8'd0,   0, 3};
    tbl[4] = '{8'd7,   1, 0, 1,  1, 8'd7,   1, 4};
    tbl[5] = '{8'd9,   1, 0, 1,  1, 8'd2,   1, 5};
    tbl[6] = '{8'd4,   1, 1, 1,  1, 8'd4,   1, 6};
    tbl[7] = '{8'd0,   0, 1, 1,  0, 8'd0,   0, 6};
    tbl[8] = '{8'd6,   1, 0, 1,  1, 8'd6,   1, 7};
    tbl[9] = '{8'd0,   0, 0, 1,  0, 8'd0,   0, 7};

    #3;
    do_reset();

    // Basic decode and sync behaviour from the table.
    for (int i = 0; i < 10; i++) begin
      bus.in_data   = tbl[i].din;
      bus.in_valid  = tbl[i].vld;
      bus.sync      = tbl[i].syn;
      bus.out_ready = tbl[i].ordy;
      cyc();
      chk($sformatf("tbl%0d_out_valid", i), int'(bus.out_valid), int'(tbl[i].exp_ov));
      chk($sformatf("tbl%0d_level", i), int'(level), tbl[i].exp_lvl);
      chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_in_ready", i), int'(bus.in_ready), 1);
      if (tbl[i].exp_ov)
        chk($sformatf("tbl%0d_out_data", i), int'(bus.out_data), int'(tbl[i].exp_od));
    end
    idle_inputs();

    // Backpressure: fill to DEPTH, hold the fifth sample, then drain.
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_data = 8'((i + 1) * 10);
      cyc();
    end
    bus.in_data = 8'd50;
    cyc();
    cyc();
    chk("bp_level_full", int'(level), 4);
    chk("bp_in_ready_full", int'(bus.in_ready), 0);
    chk("bp_count_held", int'(count), 4);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20 && got.size() < 5; t++) begin
      cyc();
      if (last_acc) bus.in_valid = 1'b0;
    end
    chk("bp_drained", got.size(), 5);
    for (int i = 0; i < got.size(); i++)
      chk($sformatf("bp_out%0d", i), int'(got[i]), 10);
    chk("bp_max_level", max_lvl, 4);
    chk("bp_count", int'(count), 5);
    idle_inputs();

    // Simultaneous push/pop at level 2 across several pointer wraps.
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd1;
    cyc();
    bus.in_data  = 8'd2;
    cyc();
    chk("wrap_level_pre", int'(level), 2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 8'((i + 1) * 7);
      cyc();
      chk($sformatf("wrap_level%0d", i), int'(level), 2);
    end
    chk("wrap_count", int'(count), 22);
    bus.in_valid = 1'b0;
    for (int t = 0; t < 10 && got.size() < 22; t++) cyc();
    chk("wrap_total", got.size(), 22);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd5);
    for (int i = 0; i < 19; i++) exp_q.push_back(8'd7);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("wrap_out%0d", i), int'(got[i]), int'(exp_q[i]));
    idle_inputs();

    // Reset in the middle of a partly full FIFO.
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 8'(i + 1);
      cyc();
    end
    chk("mid_level_pre", int'(level), 3);
    do_reset();
    chk("mid_count_released", int'(count), 0);
    bus.in_data   = 8'd100;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    cyc();
    bus.in_valid = 1'b0;
    chk("mid_out_valid", int'(bus.out_valid), 1);
    chk("mid_out_data", int'(bus.out_data), 100);
    chk("mid_count", int'(count), 1);
    idle_inputs();

    // Long run through the encoder model; counter wraps past 0xFFFF.
    do_reset();
    acc_m = 8'd0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      cur   = 8'($urandom);
      acc_m = acc_m + cur;
      bus.in_data = acc_m;
      exp_q.push_back(cur);
      cyc();
    end
    chk("long_count_wrap", int'(count), 1);
    bus.in_valid = 1'b0;
    for (int t = 0; t < 10 && got.size() < 65537; t++) cyc();
    chk("long_total", got.size(), 65537);
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("long_out%0d", i), int'(got[i]), int'(exp_q[i]));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
